// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: AES-CTR keystream front end with prefetch and message framing.
//
// Issues counter blocks to an external AES engine, which owns the key. The engine
// returns the keystream in request order and with no backpressure. Returned
// keystream blocks are kept in a small FIFO. Each accepted payload block is XORed
// with the head of the FIFO. Masked bytes come out as zero.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   iv_i / iv_valid_i     initial counter block; starts a message (IDLE or WRAP)
//   din_*                 payload stream in (data, byte keep, last, valid/ready)
//   dout_*                payload XOR keystream out (data, keep, last, valid/ready)
//   enc_req_*             counter block to the cipher (valid/ready)
//   enc_rsp_*             keystream block from the cipher (valid only, in order)
//   busy_o                state is not IDLE
//   err_wrap_o            every counter value of the message has been used
module aes_ctr_stream #(
  parameter int unsigned CTR_W = 32,  // low IV bits that increment, 2..128
  parameter int unsigned DEPTH = 4    // FIFO depth and request credits, power of 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] iv_i,
  input  logic         iv_valid_i,
  input  logic [127:0] din_i,
  input  logic [15:0]  din_keep_i,
  input  logic         din_last_i,
  input  logic         din_valid_i,
  output logic         din_ready_o,
  output logic [127:0] dout_o,
  output logic [15:0]  dout_keep_o,
  output logic         dout_last_o,
  output logic         dout_valid_o,
  input  logic         dout_ready_i,
  output logic [127:0] enc_req_o,
  output logic         enc_req_valid_o,
  input  logic         enc_req_ready_i,
  input  logic [127:0] enc_rsp_i,
  input  logic         enc_rsp_valid_i,
  output logic         busy_o,
  output logic         err_wrap_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counts 0..DEPTH inclusive, so one bit wider than a FIFO pointer.
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);
  // Ones over the incrementing part of the counter block.
  localparam logic [127:0] LowMask = {128{1'b1}} >> (128 - CTR_W);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StWrap} state_e;

  state_e state_q, state_d;

  logic [127:0]   ctr_q, ctr_d;
  // One extra bit: the MSB sets exactly when all 2^CTR_W values have been issued.
  logic [CTR_W:0] issued_q, issued_d;
  logic [CW-1:0]  outst_q, outst_d;

  logic [127:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [127:0]   dout_q, dout_d;
  logic [15:0]    keep_q, keep_d;
  logic           last_q, last_d;
  logic           valid_q, valid_d;

  logic           exhausted;
  logic           out_free;
  logic           req_valid;
  logic           req_hs;
  logic           din_ready;
  logic           din_hs;
  logic           push;
  logic           iv_load;
  logic           fifo_clr;
  logic [127:0]   ks;
  logic [127:0]   ctr_inc;

  // Handshake and control decode
  always_comb begin
    exhausted = issued_q[CTR_W];
    out_free  = !valid_q || dout_ready_i;
    req_valid = (state_q == StRun) && !exhausted &&
                (({1'b0, count_q} + {1'b0, outst_q}) < DepthW);
    req_hs    = req_valid && enc_req_ready_i;
    din_ready = (state_q == StRun) && (count_q != '0) && out_free;
    din_hs    = din_valid_i && din_ready;
    // Responses are only kept while a message is running; otherwise dropped.
    push      = enc_rsp_valid_i && (state_q == StRun);
    iv_load   = iv_valid_i && ((state_q == StIdle) || (state_q == StWrap));
    // Keystream never survives into another message.
    fifo_clr  = iv_load || (state_q == StFlush);
    ks        = mem_q[rd_ptr_q];
    ctr_inc   = ctr_q + 128'd1;
  end

  // State machine
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (iv_valid_i) state_d = StRun;
      end
      StRun: begin
        if (din_hs && din_last_i) begin
          state_d = StFlush;
        end else if (exhausted && (outst_q == '0) && (count_q == '0)) begin
          state_d = StWrap;
        end
      end
      StFlush: begin
        // Wait for all in-flight keystream to drain and the last block to leave.
        if ((outst_q == '0) && out_free) state_d = StIdle;
      end
      StWrap: begin
        if (iv_valid_i) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter, issue count and outstanding requests
  always_comb begin
    ctr_d    = ctr_q;
    issued_d = issued_q;
    if (iv_load) begin
      ctr_d    = iv_i;
      issued_d = '0;
    end else if (req_hs) begin
      // Carry out of the low field is discarded; upper IV bits stay fixed.
      ctr_d    = (ctr_inc & LowMask) | (ctr_q & ~LowMask);
      issued_d = issued_q + (CTR_W + 1)'(1);
    end

    outst_d = outst_q + CW'(req_hs);
    // A response with nothing outstanding is stale (e.g. from before reset).
    if (enc_rsp_valid_i && (outst_q != '0)) outst_d = outst_d - CW'(1);
  end

  // Keystream FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (din_hs) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, din_hs})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Output register: one cycle after a din handshake, held while stalled
  always_comb begin
    dout_d  = dout_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (din_hs) begin
      for (int i = 0; i < 16; i++) begin
        dout_d[8*i +: 8] = din_keep_i[i] ? (din_i[8*i +: 8] ^ ks[8*i +: 8]) : 8'h00;
      end
      keep_d  = din_keep_i;
      last_d  = din_last_i;
      valid_d = 1'b1;
    end else if (dout_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ctr_q    <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      keep_q   <= keep_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

  // Storage only; occupancy and pointers carry the reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_rsp_i;
  end

  assign din_ready_o     = din_ready;
  assign dout_o          = dout_q;
  assign dout_keep_o     = keep_q;
  assign dout_last_o     = last_q;
  assign dout_valid_o    = valid_q;
  assign enc_req_o       = ctr_q;
  assign enc_req_valid_o = req_valid;
  assign busy_o          = (state_q != StIdle);
  assign err_wrap_o      = (state_q == StWrap);

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Directed bench for aes_ctr_stream. Three instances (CTR_W = 32, 8, 2) share
// payload data and clock/reset; each has its own valids and its own cipher model.
// The model answers in order with a random latency and logs every accepted request.
module tb_aes_ctr_stream;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] iv_d, din_d;
  logic [15:0]  keep_d;
  logic         last_d;
  logic         dout_ready, req_ready;
  logic         iv_valid   [NI];
  logic         din_valid  [NI];
  logic         din_ready  [NI];
  logic [127:0] dout       [NI];
  logic [15:0]  dout_keep  [NI];
  logic         dout_last  [NI];
  logic         dout_valid [NI];
  logic [127:0] req        [NI];
  logic         req_valid  [NI];
  logic         busy       [NI];
  logic         err        [NI];

  int lat_base = 1;
  int n_vec = 0;
  int n_err = 0;

  // Keystream source: the four SP800-38A CTR output blocks, else a fixed scramble.
  function automatic logic [127:0] ks_of(input logic [127:0] c);
    case (c)
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff: return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00: return 128'h362b7c3c6773516318a077d7fc5073ae;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01: return 128'h6a2cc3787889374fbeb4c81b17ba6c44;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02: return 128'he89c399ff0f198c6d40a31db156cabfe;
      default: return {c[63:0], c[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned CW = (g == 0) ? 32 : ((g == 1) ? 8 : 2);
    logic         rsp_valid = 1'b0;
    logic [127:0] rsp_data  = '0;
    logic [127:0] req_log  [$];
    logic [127:0] pend_ctr [$];
    int           pend_due [$];
    int           cyc = 0;
    int           last_due = 0;

    aes_ctr_stream #(.CTR_W(CW), .DEPTH(4)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .iv_i           (iv_d),
      .iv_valid_i     (iv_valid[g]),
      .din_i          (din_d),
      .din_keep_i     (keep_d),
      .din_last_i     (last_d),
      .din_valid_i    (din_valid[g]),
      .din_ready_o    (din_ready[g]),
      .dout_o         (dout[g]),
      .dout_keep_o    (dout_keep[g]),
      .dout_last_o    (dout_last[g]),
      .dout_valid_o   (dout_valid[g]),
      .dout_ready_i   (dout_ready),
      .enc_req_o      (req[g]),
      .enc_req_valid_o(req_valid[g]),
      .enc_req_ready_i(req_ready),
      .enc_rsp_i      (rsp_data),
      .enc_rsp_valid_i(rsp_valid),
      .busy_o         (busy[g]),
      .err_wrap_o     (err[g])
    );

    always @(posedge clk) begin
      int due;
      cyc++;
      rsp_valid <= 1'b0;
      if (pend_ctr.size() > 0 && pend_due[0] <= cyc) begin
        rsp_data  <= ks_of(pend_ctr[0]);
        rsp_valid <= 1'b1;
        void'(pend_ctr.pop_front());
        void'(pend_due.pop_front());
      end
      if (req_valid[g] && req_ready) begin
        due = cyc + lat_base + int'($urandom_range(0, 4));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_ctr.push_back(req[g]);
        pend_due.push_back(due);
        req_log.push_back(req[g]);
      end
    end
  end

  function automatic int log_size(input int k);
    case (k)
      0:       return g_inst[0].req_log.size();
      1:       return g_inst[1].req_log.size();
      default: return g_inst[2].req_log.size();
    endcase
  endfunction

  function automatic logic [127:0] log_at(input int k, input int i);
    if (i >= log_size(k)) return 'x;
    case (k)
      0:       return g_inst[0].req_log[i];
      1:       return g_inst[1].req_log[i];
      default: return g_inst[2].req_log[i];
    endcase
  endfunction

  task automatic log_clear(input int k);
    case (k)
      0:       g_inst[0].req_log.delete();
      1:       g_inst[1].req_log.delete();
      default: g_inst[2].req_log.delete();
    endcase
  endtask

  // Instance-0 monitor: output log, stall stability, credit bound.
  logic [127:0] mon_data [$];
  logic         mon_last [$];
  bit           mon_en = 1'b0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_data;
  int           inflight = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall && dout_valid[0]) begin
        n_vec++;
        if (dout[0] !== prev_data) begin
          n_err++;
          $display("FAIL stall_stable: dout=%h required=%h", dout[0], prev_data);
        end
      end
      prev_stall = dout_valid[0] && !dout_ready;
      prev_data  = dout[0];
      if (dout_valid[0] && dout_ready) begin
        mon_data.push_back(dout[0]);
        mon_last.push_back(dout_last[0]);
      end
      if (req_valid[0] && req_ready) inflight++;
      if (din_valid[0] && din_ready[0]) inflight--;
      n_vec++;
      if (inflight > 4) begin
        n_err++;
        $display("FAIL credit_bound: in_flight=%0d required<=4", inflight);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_iv(input int k, input logic [127:0] v);
    iv_d = v;
    iv_valid[k] = 1'b1;
    step();
    iv_valid[k] = 1'b0;
  endtask

  // Offer one block; returns after the handshake edge (output register loaded).
  task automatic send(input int k, input logic [127:0] d, input logic [15:0] kp,
                      input logic lst, output bit ok);
    din_d = d;
    keep_d = kp;
    last_d = lst;
    din_valid[k] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = din_ready[k];
      @(posedge clk);
      #1;
    end
    din_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int c = 0; c < 100 && busy[k] !== 1'b0; c++) step();
    n_vec++;
    if (busy[k] !== 1'b0) begin
      n_err++;
      $display("FAIL idle_%0d: busy=%b required=0", k, busy[k]);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({din_ready[k], dout_valid[k], dout[k], dout_keep[k], dout_last[k], req_valid[k],
           req[k], busy[k], err[k]} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs_%0d: dout=%h req=%h busy=%b required all 0",
                 k, dout[k], req[k], busy[k]);
      end
    end
    rst = 1'b0;
    repeat (2) step();
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({busy[k], req_valid[k], din_ready[k]} !== 3'b000) begin
        n_err++;
        $display("FAIL idle_after_reset_%0d: busy=%b req_valid=%b required 0",
                 k, busy[k], req_valid[k]);
      end
    end
  endtask

  task automatic test_nist();
    logic [127:0] pt [4];
    logic [127:0] ct [4];
    logic [127:0] ec [4];
    bit ok;
    pt = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
           128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    ct = '{128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff,
           128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h1e031dda2fbe03d1792170a0f3009cee};
    ec = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00,
           128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02};
    log_clear(0);
    load_iv(0, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    n_vec++;
    if (busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL nist_busy: busy=%b required=1", busy[0]);
    end
    for (int i = 0; i < 4; i++) begin
      send(0, pt[i], 16'hffff, 1'(i == 3), ok);
      n_vec++;
      if (!ok || dout_valid[0] !== 1'b1 || dout[0] !== ct[i]) begin
        n_err++;
        $display("FAIL nist_ct_%0d: ok=%b valid=%b dout=%h required=%h",
                 i, ok, dout_valid[0], dout[0], ct[i]);
      end
      n_vec++;
      if (dout_last[0] !== 1'(i == 3) || dout_keep[0] !== 16'hffff) begin
        n_err++;
        $display("FAIL nist_frame_%0d: last=%b keep=%h", i, dout_last[0], dout_keep[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (log_at(0, i) !== ec[i]) begin
        n_err++;
        $display("FAIL nist_req_%0d: enc_req=%h required=%h", i, log_at(0, i), ec[i]);
      end
    end
    wait_idle(0);
  endtask

  task automatic test_wrap();
    logic [127:0] c0, c1, p0, p1;
    bit ok;
    c0 = 128'h00112233445566778899aabbccddfeff;
    c1 = 128'h00112233445566778899aabbccddfe00;
    p0 = 128'h11111111222222223333333344444444;
    p1 = 128'h55555555666666667777777788888888;
    log_clear(1);
    load_iv(1, c0);
    send(1, p0, 16'hffff, 1'b0, ok);
    n_vec++;
    if (!ok || dout[1] !== (p0 ^ ks_of(c0))) begin
      n_err++;
      $display("FAIL wrap_ct0: dout=%h required=%h", dout[1], p0 ^ ks_of(c0));
    end
    send(1, p1, 16'hffff, 1'b1, ok);
    n_vec++;
    if (!ok || dout[1] !== (p1 ^ ks_of(c1))) begin
      n_err++;
      $display("FAIL wrap_ct1: dout=%h required=%h", dout[1], p1 ^ ks_of(c1));
    end
    n_vec++;
    if (log_at(1, 0) !== c0 || log_at(1, 1) !== c1) begin
      n_err++;
      $display("FAIL wrap_req: req0=%h req1=%h required %h %h",
               log_at(1, 0), log_at(1, 1), c0, c1);
    end
    wait_idle(1);
  endtask

  task automatic test_partial_last();
    logic [127:0] iva, ivb, pt, pt2, ka;
    bit ok;
    iva = 128'h000102030405060708090a0b00000100;
    ivb = 128'hffeeddccbbaa99887766554400000020;
    pt  = 128'hdeadbeefcafef00d0123456789abcdef;
    pt2 = 128'h0f0e0d0c0b0a09080706050403020100;
    ka  = ks_of(iva);
    load_iv(0, iva);
    send(0, pt, 16'hff00, 1'b1, ok);
    n_vec++;
    if (!ok || dout[0][63:0] !== 64'h0 || dout[0][127:64] !== (pt[127:64] ^ ka[127:64])) begin
      n_err++;
      $display("FAIL partial_data: dout=%h required=%h", dout[0],
               {pt[127:64] ^ ka[127:64], 64'h0});
    end
    n_vec++;
    if (dout_last[0] !== 1'b1 || dout_keep[0] !== 16'hff00) begin
      n_err++;
      $display("FAIL partial_frame: last=%b keep=%h required 1 ff00", dout_last[0],
               dout_keep[0]);
    end
    n_vec++;
    if (busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL partial_flush_busy: busy=%b required=1", busy[0]);
    end
    wait_idle(0);
    log_clear(0);
    load_iv(0, ivb);
    send(0, pt2, 16'hffff, 1'b1, ok);
    n_vec++;
    if (!ok || dout[0] !== (pt2 ^ ks_of(ivb)) || log_at(0, 0) !== ivb) begin
      n_err++;
      $display("FAIL restart: dout=%h required=%h req0=%h required=%h",
               dout[0], pt2 ^ ks_of(ivb), log_at(0, 0), ivb);
    end
    wait_idle(0);
  endtask

  function automatic logic [127:0] bb_pt(input int j);
    return {32'hc0de0000 + 32'(j), 32'h12345678, 32'h9abcdef0, 32'(j) ^ 32'h00ff00ff};
  endfunction

  task automatic test_back_to_back();
    localparam int N = 12;
    logic [127:0] ivc;
    int j;
    int guard;
    ivc = 128'h0a0b0c0d0e0f10111213141500000040;
    mon_data.delete();
    mon_last.delete();
    inflight = 0;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    log_clear(0);
    load_iv(0, ivc);
    j = 0;
    guard = 0;
    while (j < N && guard < 2000) begin
      din_d = bb_pt(j);
      keep_d = 16'hffff;
      last_d = 1'(j == N - 1);
      din_valid[0] = 1'($urandom_range(0, 1));
      dout_ready = 1'($urandom_range(0, 1));
      req_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (din_valid[0] && din_ready[0]) j++;
      @(posedge clk);
      #1;
      guard++;
    end
    din_valid[0] = 1'b0;
    dout_ready = 1'b1;
    req_ready = 1'b1;
    n_vec++;
    if (j != N) begin
      n_err++;
      $display("FAIL bb_accept: accepted=%0d required=%0d", j, N);
    end
    repeat (10) step();
    mon_en = 1'b0;
    n_vec++;
    if (mon_data.size() != N) begin
      n_err++;
      $display("FAIL bb_count: delivered=%0d required=%0d", mon_data.size(), N);
    end
    for (int i = 0; i < N && i < mon_data.size(); i++) begin
      n_vec++;
      if (mon_data[i] !== (bb_pt(i) ^ ks_of(ivc + 128'(i))) || mon_last[i] !== 1'(i == N - 1))
      begin
        n_err++;
        $display("FAIL bb_block_%0d: dout=%h last=%b required=%h", i, mon_data[i],
                 mon_last[i], bb_pt(i) ^ ks_of(ivc + 128'(i)));
      end
    end
    wait_idle(0);
  endtask

  task automatic test_exhaust();
    logic [127:0] ivd, ive, pe;
    logic [127:0] ce [4];
    bit ok;
    ivd = 128'h112233445566778899aabbccddeeff01;
    ive = 128'hcafebabe000000000000000000000002;
    pe  = 128'h00000000000000000000000000000000;
    ce  = '{128'h112233445566778899aabbccddeeff01, 128'h112233445566778899aabbccddeeff02,
            128'h112233445566778899aabbccddeeff03, 128'h112233445566778899aabbccddeeff00};
    log_clear(2);
    load_iv(2, ivd);
    for (int i = 0; i < 4; i++) begin
      send(2, bb_pt(i + 20), 16'hffff, 1'b0, ok);
      n_vec++;
      if (!ok || dout[2] !== (bb_pt(i + 20) ^ ks_of(ce[i]))) begin
        n_err++;
        $display("FAIL exh_block_%0d: dout=%h required=%h", i, dout[2],
                 bb_pt(i + 20) ^ ks_of(ce[i]));
      end
    end
    din_d = bb_pt(99);
    din_valid[2] = 1'b1;
    repeat (8) step();
    n_vec++;
    if (err[2] !== 1'b1 || din_ready[2] !== 1'b0 || busy[2] !== 1'b1) begin
      n_err++;
      $display("FAIL exh_wrap: err=%b din_ready=%b busy=%b required 1 0 1",
               err[2], din_ready[2], busy[2]);
    end
    n_vec++;
    if (log_size(2) != 4 || log_at(2, 3) !== ce[3]) begin
      n_err++;
      $display("FAIL exh_reqs: issued=%0d last=%h required 4 %h", log_size(2),
               log_at(2, 3), ce[3]);
    end
    din_valid[2] = 1'b0;
    load_iv(2, ive);
    n_vec++;
    if (err[2] !== 1'b0 || busy[2] !== 1'b1) begin
      n_err++;
      $display("FAIL exh_clear: err=%b busy=%b required 0 1", err[2], busy[2]);
    end
    send(2, pe, 16'hffff, 1'b1, ok);
    n_vec++;
    if (!ok || dout[2] !== ks_of(ive)) begin
      n_err++;
      $display("FAIL exh_resume: dout=%h required=%h", dout[2], ks_of(ive));
    end
    wait_idle(2);
  endtask

  task automatic test_reset_mid();
    lat_base = 12;
    log_clear(0);
    load_iv(0, 128'h55555555aaaaaaaa1234567800000000);
    for (int c = 0; c < 50 && log_size(0) < 3; c++) step();
    n_vec++;
    if (log_size(0) != 3) begin
      n_err++;
      $display("FAIL rstmid_outstanding: issued=%0d required=3", log_size(0));
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({din_ready[0], dout_valid[0], dout[0], dout_keep[0], dout_last[0], req_valid[0],
         req[0], busy[0], err[0]} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: req=%h req_valid=%b busy=%b required all 0",
               req[0], req_valid[0], busy[0]);
    end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step();
      n_vec++;
      if ({busy[0], req_valid[0], dout_valid[0], din_ready[0]} !== 4'b0000) begin
        n_err++;
        $display("FAIL rstmid_idle_%0d: busy=%b req_valid=%b dout_valid=%b required 0",
                 c, busy[0], req_valid[0], dout_valid[0]);
      end
    end
    lat_base = 1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      iv_valid[k] = 1'b0;
      din_valid[k] = 1'b0;
    end
    iv_d = '0;
    din_d = '0;
    keep_d = '0;
    last_d = 1'b0;
    dout_ready = 1'b1;
    req_ready = 1'b1;
    test_reset();
    test_nist();
    test_wrap();
    test_partial_last();
    test_back_to_back();
    test_exhaust();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_ctr_stream.md
Name: aes_ctr_stream

Overview:
- Parametrised successor of the AES-CTR engine.
- Generates counter blocks for an external AES block-cipher engine and buffers the returned keystream in a prefetch FIFO.
- XORs the keystream with a streaming, byte-masked payload, with full valid/ready backpressure on both sides.
- Adds a configurable counter width, per-message framing (last/keep) with keystream flush, and counter-exhaustion detection.
- The key is owned by the cipher engine and is not handled here.

Parameters:
- CTR_W, 32: number of low IV bits that increment. Upper 128-CTR_W bits stay fixed. Legal range 2..128.
- DEPTH, 4: keystream FIFO depth and maximum outstanding cipher requests. Power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- iv_i  in  128  initial counter block
- iv_valid_i  in  1  load IV and start a message
- din_i  in  128  payload block; byte 15 (MSB) is the first byte
- din_keep_i  in  16  byte enables; bit i covers din_i[8i+7:8i]
- din_last_i  in  1  final block of the message
- din_valid_i  in  1  payload valid
- din_ready_o  out  1  payload accepted
- dout_o  out  128  payload XOR keystream, with masked bytes zeroed
- dout_keep_o  out  16  copy of din_keep_i
- dout_last_o  out  1  copy of din_last_i
- dout_valid_o  out  1  output valid
- dout_ready_i  in  1  downstream ready
- enc_req_o  out  128  counter block sent to the cipher
- enc_req_valid_o  out  1  request valid
- enc_req_ready_i  in  1  cipher accepts request
- enc_rsp_i  in  128  encrypted counter (keystream)
- enc_rsp_valid_i  in  1  response valid; has no backpressure, and responses return in request order
- busy_o  out  1  state is not IDLE
- err_wrap_o  out  1  counter exhausted

Behaviour:
- Reset: all outputs 0, state IDLE, ctr 0, FIFO empty, outstanding 0, issued 0.
- States:
  - IDLE: iv_valid_i loads ctr=iv_i and issued=0, then goes to RUN.
  - RUN: normal operation.
  - FLUSH: entered on accepting a din_last_i block. Issues no requests, discards the FIFO contents and every response arriving. Goes to IDLE when outstanding==0 and the output register is not holding an undelivered block.
  - WRAP: entered from RUN when exhausted, outstanding==0 and FIFO empty. Sets err_wrap_o=1 and holds din_ready_o=0.
- iv_valid_i is honoured only in IDLE or WRAP. From WRAP it clears err_wrap_o, clears the FIFO and goes to RUN. It is ignored in RUN and FLUSH.
- Request issue:
  - enc_req_valid_o=1 in RUN when (fifo_count + outstanding) < DEPTH and not exhausted. enc_req_o=ctr.
  - On handshake: ctr[CTR_W-1:0] increments modulo 2^CTR_W, ctr[127:CTR_W] is unchanged, outstanding+1, issued+1.
  - exhausted = (issued == 2^CTR_W). Counter values are never reused within one message.
  - Credits guarantee the FIFO never overflows.
- Response: enc_rsp_valid_i pushes enc_rsp_i into the FIFO and decrements outstanding. In FLUSH/IDLE/WRAP the data is dropped (outstanding still decrements, floor 0).
- Data path:
  - din_ready_o = (state==RUN) & fifo_nonempty & (!dout_valid_o | dout_ready_i).
  - On din handshake, the next cycle has dout_valid_o=1 and dout_o[8i+7:8i] = keep[i] ? din^ks : 0, keep/last copied, and the FIFO is popped. Latency is exactly 1 cycle.
  - dout_* stays stable while dout_valid_o & !dout_ready_i. dout_valid_o clears when accepted with no new din.
- Simultaneous events:
  - FIFO push+pop in the same cycle leaves the count unchanged.
  - A response and a request handshake in the same cycle leave outstanding unchanged.
  - din_last accepted in the same cycle as a response: that response is still consumed into the FIFO, then flushed.
- Keystream is never carried across messages.
- Reset asserted mid-message aborts everything immediately; cipher responses after reset release are ignored (state IDLE).

Test Plan:
- NIST SP800-38A CTR vector, CTR_W=32, cipher model with random latency 1-5, dout_ready_i=1:
  - iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, pt 6bc1bee22e409f96e93d7e117393172a -> dout 874d6191b620e3261bef6864990db6ce.
  - enc_req sequence ...fcfdfeff, ...fcfdff00, ...fcfdff01, ...fcfdff02; all 4 NIST blocks match golden.
- Wrap, CTR_W=8, iv low bytes ...feff -> second enc_req_o ends ...fe00 (byte fe preserved); ciphertext equals the model using that counter.
- Partial last block: keep=16'hFF00, last=1 -> dout low 8 bytes 0, dout_last_o=1. Then FLUSH, busy_o drops once outstanding==0, and a new iv restarts at its own counter.
- Backpressure: random dout_ready_i and din_valid_i at 50% -> no loss or duplication, dout stable while stalled, outstanding+fifo never exceeds DEPTH=4.
- Exhaustion, CTR_W=2: 4 blocks OK, 5th din_valid_i -> din_ready_o=0, err_wrap_o=1, exactly 4 requests issued. iv_valid_i clears the error and RUN resumes.
- Async rst pulse mid-message with 3 outstanding -> all outputs 0 immediately; late responses are dropped, state stays IDLE.
